// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Definitions shared by the MIPS pipeline stages.
//   - Bit positions inside the MEM control field produced by the EX stage.
//   - Access size encodings.
//   - Helpers for the byte-lane mask and the alignment check, used by the MEM
//     stage for stores and loads.
// -----------------------------------------------------------------------------
package mips_pkg;

    // MEM control field: [4] write, [3] read, [2:1] size, [0] unsigned
    localparam int MEM_WR   = 4;
    localparam int MEM_RD   = 3;
    localparam int MEM_SIZE = 1;   // LSB of the 2-bit size field
    localparam int MEM_UNS  = 0;

    // Size encodings; 2'b10 is reserved and behaves as a word access
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b11;

    // Any size with bit 1 set (word or reserved) is a full-word access
    function automatic logic is_word(input logic [1:0] size);
        return size[1];
    endfunction

    // Byte lanes touched by an access of the given size at the given offset
    function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                             input logic [1:0] offset);
        logic [3:0] mask;
        if (is_word(size)) begin
            mask = 4'b1111;
        end else if (size == SZ_HALF) begin
            mask = 4'b0011 << offset;
        end else begin
            mask = 4'b0001 << offset;
        end
        return mask;
    endfunction

    // Halfwords must sit on an even byte, words on a multiple of four
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] offset);
        logic bad;
        if (is_word(size)) begin
            bad = (offset != 2'b00);
        end else if (size == SZ_HALF) begin
            bad = offset[0];
        end else begin
            bad = 1'b0;
        end
        return bad;
    endfunction

endpackage

// File: rtl/data_ram.sv
// -----------------------------------------------------------------------------
// data_ram
// (2^NB_ADDR) x 32-bit data memory, written as a plain array with registered
// reads so that it maps onto a dual-port block RAM.
//   Port A: read/write, read-first, 4-bit byte write enable, read register
//           updated only when i_en_a is high.
//   Port B: read-only (debug), read-first, registered every cycle, output
//           register cleared by reset.
// Ports:
//   i_clock, i_reset          clock, synchronous active-high reset
//   i_en_a                    port A enable (read register update)
//   i_we_a[3:0]               port A byte write enables, bit i = bits [8i+7:8i]
//   i_addr_a, i_wdata_a       port A word address and write data
//   o_rdata_a                 port A registered (pre-write) word
//   i_addr_b, o_rdata_b       port B word address and registered word
// -----------------------------------------------------------------------------
module data_ram #(
    parameter int NB_ADDR = 10
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_en_a,
    input  logic [3:0]         i_we_a,
    input  logic [NB_ADDR-1:0] i_addr_a,
    input  logic [31:0]        i_wdata_a,
    output logic [31:0]        o_rdata_a,
    input  logic [NB_ADDR-1:0] i_addr_b,
    output logic [31:0]        o_rdata_b
);

    localparam int DEPTH = 1 << NB_ADDR;

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_a_q;
    logic [31:0] rdata_b_q;

    // Port A: the read register samples the word before this cycle's write
    always_ff @(posedge i_clock) begin
        if (i_en_a) begin
            rdata_a_q <= mem[i_addr_a];
        end
        for (int lane = 0; lane < 4; lane++) begin
            if (i_we_a[lane]) begin
                mem[i_addr_a][lane*8 +: 8] <= i_wdata_a[lane*8 +: 8];
            end
        end
    end

    // Port B: debug read, independent of the pipeline enable
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            rdata_b_q <= '0;
        end else begin
            rdata_b_q <= mem[i_addr_b];
        end
    end

    assign o_rdata_a = rdata_a_q;
    assign o_rdata_b = rdata_b_q;

endmodule

// File: rtl/memory_access.sv
// -----------------------------------------------------------------------------
// memory_access
// MEM stage of the five-stage MIPS pipeline. Performs the data-memory
// load/store for the EX/MEM bundle and registers the MEM/WB bundle.
// Ports:
//   i_clock, i_reset   clock, synchronous active-high reset
//   i_valid            stage enable; low holds all pipeline state
//   i_alu              byte address / ALU result
//   i_b                store data
//   i_mem              [4] write, [3] read, [2:1] size, [0] unsigned
//   i_wb, i_pc         passed through to the WB stage
//   i_dbg_addr         debug word address
//   o_read_data        extended load result (0 when no aligned load)
//   o_alu, o_wb, o_pc  registered pass-through fields
//   o_misaligned       registered misaligned-access flag
//   o_dbg_data         registered RAM word at i_dbg_addr
// The RAM output word is kept raw; offset, size and signedness are registered
// beside it and the lane extraction happens after the edge, which keeps the
// RAM read path free of logic so it maps to block RAM.
// -----------------------------------------------------------------------------
module memory_access
    import mips_pkg::*;
#(
    parameter int NB_REG  = 32,
    parameter int NB_MEM  = 5,
    parameter int NB_WB   = 8,
    parameter int NB_ADDR = 10
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic [NB_REG-1:0]  i_alu,
    input  logic [NB_REG-1:0]  i_b,
    input  logic [NB_MEM-1:0]  i_mem,
    input  logic [NB_WB-1:0]   i_wb,
    input  logic [NB_REG-1:0]  i_pc,
    input  logic [NB_ADDR-1:0] i_dbg_addr,
    output logic [NB_REG-1:0]  o_read_data,
    output logic [NB_REG-1:0]  o_alu,
    output logic [NB_WB-1:0]   o_wb,
    output logic [NB_REG-1:0]  o_pc,
    output logic               o_misaligned,
    output logic [NB_REG-1:0]  o_dbg_data
);

    // ---------------- request decode ----------------
    logic               req_wr;
    logic               req_rd;
    logic [1:0]         req_size;
    logic               req_uns;
    logic [1:0]         req_off;
    logic [NB_ADDR-1:0] req_word;
    logic               req_bad;
    logic [3:0]         ram_we;
    logic [31:0]        ram_wdata;
    logic [31:0]        ram_rdata;
    logic [31:0]        ram_dbg;

    assign req_wr   = i_mem[MEM_WR];
    assign req_rd   = i_mem[MEM_RD];
    assign req_size = i_mem[MEM_SIZE +: 2];
    assign req_uns  = i_mem[MEM_UNS];
    assign req_off  = i_alu[1:0];
    // Upper address bits are dropped, so addresses wrap around the RAM
    assign req_word = i_alu[NB_ADDR+1:2];
    assign req_bad  = (req_wr || req_rd) && is_misaligned(req_size, req_off);

    // Store path: replicate the data across all lanes, then let the lane mask
    // pick which bytes actually land in the RAM.
    always_comb begin
        ram_we    = 4'b0000;
        ram_wdata = i_b[31:0];
        if (!is_word(req_size)) begin
            if (req_size == SZ_HALF) begin
                ram_wdata = {2{i_b[15:0]}};
            end else begin
                ram_wdata = {4{i_b[7:0]}};
            end
        end
        if (i_valid && !i_reset && req_wr && !req_bad) begin
            ram_we = lane_mask(req_size, req_off);
        end
    end

    data_ram #(
        .NB_ADDR (NB_ADDR)
    ) u_data_ram (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_en_a    (i_valid),
        .i_we_a    (ram_we),
        .i_addr_a  (req_word),
        .i_wdata_a (ram_wdata),
        .o_rdata_a (ram_rdata),
        .i_addr_b  (i_dbg_addr),
        .o_rdata_b (ram_dbg)
    );

    // ---------------- pipeline registers ----------------
    logic [NB_REG-1:0] alu_d,  alu_q;
    logic [NB_WB-1:0]  wb_d,   wb_q;
    logic [NB_REG-1:0] pc_d,   pc_q;
    logic              mis_d,  mis_q;
    logic              load_d, load_q;
    logic [1:0]        off_d,  off_q;
    logic [1:0]        size_d, size_q;
    logic              uns_d,  uns_q;

    always_comb begin
        alu_d  = alu_q;
        wb_d   = wb_q;
        pc_d   = pc_q;
        mis_d  = mis_q;
        load_d = load_q;
        off_d  = off_q;
        size_d = size_q;
        uns_d  = uns_q;
        if (i_valid) begin
            alu_d  = i_alu;
            wb_d   = i_wb;
            pc_d   = i_pc;
            mis_d  = req_bad;
            load_d = req_rd && !req_bad;
            off_d  = req_off;
            size_d = req_size;
            uns_d  = req_uns;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            alu_q  <= '0;
            wb_q   <= '0;
            pc_q   <= '0;
            mis_q  <= 1'b0;
            load_q <= 1'b0;
            off_q  <= 2'b00;
            size_q <= 2'b00;
            uns_q  <= 1'b0;
        end else begin
            alu_q  <= alu_d;
            wb_q   <= wb_d;
            pc_q   <= pc_d;
            mis_q  <= mis_d;
            load_q <= load_d;
            off_q  <= off_d;
            size_q <= size_d;
            uns_q  <= uns_d;
        end
    end

    // ---------------- load extraction ----------------
    logic [15:0] half_sel;
    logic [7:0]  byte_sel;
    logic [31:0] load_ext;

    always_comb begin
        half_sel = off_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        case (off_q)
            2'd0:    byte_sel = ram_rdata[7:0];
            2'd1:    byte_sel = ram_rdata[15:8];
            2'd2:    byte_sel = ram_rdata[23:16];
            default: byte_sel = ram_rdata[31:24];
        endcase

        load_ext = 32'd0;
        if (load_q) begin
            if (is_word(size_q)) begin
                load_ext = ram_rdata;
            end else if (size_q == SZ_HALF) begin
                load_ext = uns_q ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            end else begin
                load_ext = uns_q ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
        end
    end

    assign o_read_data  = NB_REG'(load_ext);
    assign o_alu        = alu_q;
    assign o_wb         = wb_q;
    assign o_pc         = pc_q;
    assign o_misaligned = mis_q;
    assign o_dbg_data   = NB_REG'(ram_dbg);

endmodule

// File: tb/tb_memory_access.sv
// -----------------------------------------------------------------------------
// tb_memory_access
// Directed scoreboard bench for memory_access. Each issued bundle pushes its
// expected MEM/WB outputs; a monitor pops one entry per checked cycle on the
// falling edge after the capturing rising edge and compares every field.
// -----------------------------------------------------------------------------
module tb_memory_access;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [31:0] alu, b, pc;
    logic [4:0]  mem;
    logic [7:0]  wb;
    logic [9:0]  dbg_addr;
    logic [31:0] read_data, o_alu, o_pc, dbg_data;
    logic [7:0]  o_wb;
    logic        mis;

    memory_access #(
        .NB_REG  (32),
        .NB_MEM  (5),
        .NB_WB   (8),
        .NB_ADDR (10)
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_valid      (valid),
        .i_alu        (alu),
        .i_b          (b),
        .i_mem        (mem),
        .i_wb         (wb),
        .i_pc         (pc),
        .i_dbg_addr   (dbg_addr),
        .o_read_data  (read_data),
        .o_alu        (o_alu),
        .o_wb         (o_wb),
        .o_pc         (o_pc),
        .o_misaligned (mis),
        .o_dbg_data   (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // MEM control encodings: {write, read, size[1:0], unsigned}
    localparam logic [4:0] M_NONE = 5'b00000;
    localparam logic [4:0] M_SW   = 5'b10110;
    localparam logic [4:0] M_SH   = 5'b10010;
    localparam logic [4:0] M_SB   = 5'b10000;
    localparam logic [4:0] M_LW   = 5'b01110;
    localparam logic [4:0] M_LH   = 5'b01010;
    localparam logic [4:0] M_LHU  = 5'b01011;
    localparam logic [4:0] M_LB   = 5'b01000;
    localparam logic [4:0] M_LBU  = 5'b01001;
    localparam logic [4:0] M_RW   = 5'b11110;

    typedef struct packed {
        logic [31:0] rd;
        logic [31:0] alu;
        logic [7:0]  wb;
        logic [31:0] pc;
        logic        mis;
        logic        chk_dbg;
        logic [31:0] dbg;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    exp_t  last_exp;
    int    n_txn;
    int    tests;
    int    fails;
    logic  chk;
    logic  chk_d;
    logic  done;

    function automatic void cmp(input string nm, input string fld,
                                input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s.%s got 0x%08h expected 0x%08h", nm, fld, act, req);
        end
    endfunction

    // Marks which rising edges capture a checked bundle
    always @(posedge clk) chk_d <= chk;

    // Monitor: compare DUT outputs against the scoreboard head
    always @(negedge clk) begin
        if (chk_d) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL scoreboard_underflow got empty expected entry");
            end else begin
                exp_t  e;
                string nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                cmp(nm, "read_data", read_data, e.rd);
                cmp(nm, "alu", o_alu, e.alu);
                cmp(nm, "wb", {24'd0, o_wb}, {24'd0, e.wb});
                cmp(nm, "pc", o_pc, e.pc);
                cmp(nm, "misaligned", {31'd0, mis}, {31'd0, e.mis});
                if (e.chk_dbg) cmp(nm, "dbg_data", dbg_data, e.dbg);
                $display("[TB] %-14s rd=0x%08h alu=0x%08h wb=0x%02h pc=0x%08h mis=%0b dbg=0x%08h",
                         nm, read_data, o_alu, o_wb, o_pc, mis, dbg_data);
            end
        end
        if (done) begin
            cmp("final", "pending", exp_q.size(), 0);
            done <= 1'b0;
        end
    end

    // Issue one bundle for one clock and queue what the outputs must show
    task automatic op(input string nm, input logic r, input logic v,
                      input logic [31:0] a, input logic [31:0] bd, input logic [4:0] m,
                      input logic [9:0] da, input logic [31:0] exp_rd, input logic exp_mis,
                      input logic cd, input logic [31:0] exp_dbg);
        exp_t e;
        logic [31:0] this_pc;
        logic [7:0]  this_wb;
        this_pc = 32'h400 + 32'(n_txn) * 4;
        this_wb = 8'(n_txn) ^ 8'hA0;
        n_txn++;
        if (r) begin
            e = '0;
        end else if (v) begin
            e.rd  = exp_rd;
            e.alu = a;
            e.wb  = this_wb;
            e.pc  = this_pc;
            e.mis = exp_mis;
        end else begin
            e = last_exp;
        end
        last_exp  = e;
        last_exp.chk_dbg = 1'b0;
        e.chk_dbg = cd;
        e.dbg     = exp_dbg;
        exp_q.push_back(e);
        name_q.push_back(nm);
        rst      = r;
        valid    = v;
        alu      = a;
        b        = bd;
        mem      = m;
        wb       = this_wb;
        pc       = this_pc;
        dbg_addr = da;
        chk      = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; alu = '0; b = '0; mem = '0;
        wb = '0; pc = '0; dbg_addr = '0;
        chk = 1'b0; chk_d = 1'b0; done = 1'b0;
        tests = 0; fails = 0; n_txn = 0; last_exp = '0;
        repeat (2) @(posedge clk);
        #1;

        // Seed a word, then present a store while in reset
        op("seed_30",     0, 1, 32'h30,   32'hA5A5A5A5, M_SW,  10'h00C, 32'h0,        0, 0, 32'h0);
        op("reset_store", 1, 1, 32'h30,   32'h11111111, M_SW,  10'h00C, 32'h0,        0, 1, 32'h0);
        op("lw_30",       0, 1, 32'h30,   32'h0,        M_LW,  10'h00C, 32'hA5A5A5A5, 0, 1, 32'hA5A5A5A5);

        // Word / byte / half store and load
        op("sw_10",       0, 1, 32'h10,   32'hDEADBEEF, M_SW,  10'h000, 32'h0,        0, 0, 32'h0);
        op("lw_10",       0, 1, 32'h10,   32'h0,        M_LW,  10'h000, 32'hDEADBEEF, 0, 0, 32'h0);
        op("sb_13",       0, 1, 32'h13,   32'h12345680, M_SB,  10'h000, 32'h0,        0, 0, 32'h0);
        op("lb_13",       0, 1, 32'h13,   32'h0,        M_LB,  10'h000, 32'hFFFFFF80, 0, 0, 32'h0);
        op("lbu_13",      0, 1, 32'h13,   32'h0,        M_LBU, 10'h000, 32'h00000080, 0, 0, 32'h0);
        op("lw_10_b",     0, 1, 32'h10,   32'h0,        M_LW,  10'h000, 32'h80ADBEEF, 0, 0, 32'h0);
        op("sh_11_mis",   0, 1, 32'h11,   32'h00001234, M_SH,  10'h000, 32'h0,        1, 0, 32'h0);
        op("lw_10_c",     0, 1, 32'h10,   32'h0,        M_LW,  10'h000, 32'h80ADBEEF, 0, 0, 32'h0);
        op("lh_12",       0, 1, 32'h12,   32'h0,        M_LH,  10'h000, 32'hFFFF80AD, 0, 0, 32'h0);
        op("lhu_10",      0, 1, 32'h10,   32'h0,        M_LHU, 10'h000, 32'h0000BEEF, 0, 0, 32'h0);
        op("lw_12_mis",   0, 1, 32'h12,   32'h0,        M_LW,  10'h000, 32'h0,        1, 0, 32'h0);
        op("lb_11",       0, 1, 32'h11,   32'h0,        M_LB,  10'h000, 32'hFFFFFFBE, 0, 0, 32'h0);

        // Read+write in one cycle returns the old word; address wrap
        op("rw_10",       0, 1, 32'h10,   32'h01020304, M_RW,  10'h000, 32'h80ADBEEF, 0, 0, 32'h0);
        op("lw_wrap",     0, 1, 32'h1010, 32'h0,        M_LW,  10'h000, 32'h01020304, 0, 0, 32'h0);

        // Stall with a store held on the bus
        op("sw_20",       0, 1, 32'h20,   32'h0BADF00D, M_SW,  10'h008, 32'h0,        0, 0, 32'h0);
        op("lw_10_d",     0, 1, 32'h10,   32'h0,        M_LW,  10'h008, 32'h01020304, 0, 1, 32'h0BADF00D);
        for (int i = 0; i < 3; i++) begin
            op("stall",   0, 0, 32'h20,   32'h55667788, M_SW,  10'h008, 32'h0,        0, 1, 32'h0BADF00D);
        end
        op("stall_rel",   0, 1, 32'h20,   32'h55667788, M_SW,  10'h008, 32'h0,        0, 1, 32'h0BADF00D);
        op("lw_20",       0, 1, 32'h20,   32'h0,        M_LW,  10'h008, 32'h55667788, 0, 1, 32'h55667788);

        // Debug port read-first against a same-cycle store
        op("sw_40",       0, 1, 32'h40,   32'h76543210, M_SW,  10'h010, 32'h0,        0, 0, 32'h0);
        op("sw_40_dbg",   0, 1, 32'h40,   32'hCAFEF00D, M_SW,  10'h010, 32'h0,        0, 1, 32'h76543210);
        op("lw_40",       0, 1, 32'h40,   32'h0,        M_LW,  10'h010, 32'hCAFEF00D, 0, 1, 32'hCAFEF00D);
        op("nop_40",      0, 1, 32'h40,   32'hFFFFFFFF, M_NONE,10'h010, 32'h0,        0, 1, 32'hCAFEF00D);

        chk   = 1'b0;
        valid = 1'b0;
        repeat (2) @(posedge clk);
        done = 1'b1;
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
